// File: rtl/ro_freq_meter_ctrl.sv
// Ring-oscillator frequency measurement sequencer.
// Enables the RO, lets it settle, counts synchronized rising edges of ro_clk over a
// programmable window of clk cycles, then disables the RO and flushes the
// synchronizer before reporting the count.
module ro_freq_meter_ctrl #(
    parameter int CNT_W         = 16,
    parameter int GATE_W        = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              ro_clk,
    output logic              ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    // Phase timer must hold the gate length as well as the settle/drain lengths.
    localparam int TMR_W = (GATE_W > 16) ? GATE_W : 16;
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    // DRAIN spans SYNC_STAGES+1 cycles so every edge already in the synchronizer drops out.
    localparam logic [TMR_W-1:0] DRAIN_LOAD  = TMR_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                ro_en_q, ro_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                sync_prev_q, sync_prev_d;
    logic                sync_out_s;
    logic                rise_s;
    logic                timer_zero_s;
    logic [TMR_W-1:0]    timer_dec_s;

    assign sync_out_s   = sync_q[SYNC_STAGES-1];
    assign rise_s       = sync_out_s & ~sync_prev_q;
    assign timer_zero_s = (timer_q == {TMR_W{1'b0}});
    assign timer_dec_s  = timer_q - TMR_ONE;

    // Next-state logic for the synchronizer, edge detector, phase FSM and result registers.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], ro_clk};
        sync_prev_d = sync_out_s;
        state_d     = state_q;
        timer_d     = timer_q;
        gate_d      = gate_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        ro_en_d     = ro_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        aborted_d   = aborted_q;
        case (state_q)
            ST_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    state_d    = ST_SETTLE;
                    timer_d    = SETTLE_LOAD;
                    gate_d     = gate_cycles;
                    count_d    = {CNT_W{1'b0}};
                    overflow_d = 1'b0;
                    ro_en_d    = 1'b1;
                    busy_d     = 1'b1;
                    aborted_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d   = ST_DRAIN;
                    timer_d   = DRAIN_LOAD;
                    ro_en_d   = 1'b0;
                    aborted_d = 1'b1;
                end else if (timer_zero_s) begin
                    if (gate_q == {GATE_W{1'b0}}) begin
                        state_d = ST_DRAIN;
                        timer_d = DRAIN_LOAD;
                        ro_en_d = 1'b0;
                    end else begin
                        state_d = ST_GATE;
                        timer_d = TMR_W'(gate_q) - TMR_ONE;
                    end
                end else begin
                    timer_d = timer_dec_s;
                end
            end
            ST_GATE: begin
                if (abort) begin
                    state_d   = ST_DRAIN;
                    timer_d   = DRAIN_LOAD;
                    ro_en_d   = 1'b0;
                    aborted_d = 1'b1;
                end else begin
                    if (rise_s) begin
                        if (count_q == CNT_MAX) begin
                            overflow_d = 1'b1;
                        end else begin
                            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        count_d = count_q;
                    end
                    if (timer_zero_s) begin
                        state_d = ST_DRAIN;
                        timer_d = DRAIN_LOAD;
                        ro_en_d = 1'b0;
                    end else begin
                        timer_d = timer_dec_s;
                    end
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                end else begin
                    aborted_d = aborted_q;
                end
                if (timer_zero_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = !(aborted_q || abort);
                end else begin
                    timer_d = timer_dec_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ro_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the RO off immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= {TMR_W{1'b0}};
            gate_q      <= {GATE_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            overflow_q  <= 1'b0;
            ro_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            sync_q      <= {SYNC_STAGES{1'b0}};
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            gate_q      <= gate_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            ro_en_q     <= ro_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            sync_q      <= sync_d;
            sync_prev_q <= sync_prev_d;
        end
    end

    assign ro_en    = ro_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ro_freq_meter_ctrl.sv
// Self-checking bench for ro_freq_meter_ctrl: behavioural ring-oscillator models drive
// ro_clk, and expected latency/count come from plain arithmetic on the timing rules.
module tb_ro_freq_meter_ctrl;

    localparam int SETTLE = 8;
    localparam int SS     = 2;

    logic        clk;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] gate_cycles;
    logic        ro_clk, ro_en, busy, done, overflow;
    logic [15:0] count;

    logic        start4, abort4;
    logic [15:0] gate4;
    logic        ro_clk4, ro_en4, busy4, done4, overflow4;
    logic [3:0]  count4;

    int ro_half;
    int ro_half4;

    int n_checks;
    int n_fail;

    int obs_lat, obs_lat2, obs_ndone, obs_busy_at_done, obs_roen_last, obs_busy_last;
    logic [15:0] obs_count;
    logic        obs_ovf;

    ro_freq_meter_ctrl #(.CNT_W(16), .GATE_W(16), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_cycles(gate_cycles),
        .ro_clk(ro_clk), .ro_en(ro_en), .busy(busy), .done(done), .count(count), .overflow(overflow)
    );

    ro_freq_meter_ctrl #(.CNT_W(4), .GATE_W(16), .SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SS)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .gate_cycles(gate4),
        .ro_clk(ro_clk4), .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .overflow(overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RO model: free-runs with half period ro_half while enabled; toggles never hit a clk edge
    initial begin
        ro_clk = 1'b0;
        forever begin
            @(posedge ro_en);
            #3;
            while (ro_en === 1'b1) begin
                ro_clk = ~ro_clk;
                #(ro_half);
            end
            ro_clk = 1'b0;
        end
    end

    // RO model for the narrow-counter instance
    initial begin
        ro_clk4 = 1'b0;
        forever begin
            @(posedge ro_en4);
            #3;
            while (ro_en4 === 1'b1) begin
                ro_clk4 = ~ro_clk4;
                #(ro_half4);
            end
            ro_clk4 = 1'b0;
        end
    end

    // Reference model: edges in a window of g clk cycles (10 ns) for RO period 2*half, +/-1 for sync phase
    function automatic int exp_lo(input int g, input int half);
        int v;
        v = (g * 10) / (2 * half) - 1;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int exp_hi(input int g, input int half);
        return (g * 10 + 2 * half - 1) / (2 * half) + 1;
    endfunction

    // Stimulus/observation: pulse start, then watch outputs each cycle (cycle 1 = first cycle after acceptance edge).
    // act_kind: 0 none, 1 re-pulse start (with different gate) at act_cyc, 2 abort at act_cyc, 3 start again on done cycle
    task automatic run_meas(input logic [15:0] g, input int act_kind, input int act_cyc,
                            input logic [15:0] g_alt, input int budget);
        obs_lat = -1; obs_lat2 = -1; obs_ndone = 0; obs_busy_at_done = -1;
        obs_roen_last = -1; obs_busy_last = -1;
        @(posedge clk); #1;
        gate_cycles = g;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (ro_en) obs_roen_last = c;
            if (busy) obs_busy_last = c;
            if (done) begin
                obs_ndone++;
                if (obs_lat < 0) begin
                    obs_lat = c;
                    obs_busy_at_done = int'(busy);
                    if (act_kind == 3) start = 1'b1;
                end else if (obs_lat2 < 0) begin
                    obs_lat2 = c;
                end
            end
            if (c == act_cyc && act_kind == 1) begin
                start = 1'b1;
                gate_cycles = g_alt;
            end
            if (c == act_cyc && act_kind == 2) abort = 1'b1;
        end
        obs_count = count;
        obs_ovf = overflow;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ro_en !== 1'b0) begin n_fail++; $display("FAIL reset_ro_en: got %b want 0", ro_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++; if (count4 !== 4'd0 || busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4: count %0d busy %b want 0 0", count4, busy4); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        ro_half = 25;
        run_meas(16'd100, 0, 0, 16'd0, 118);
        n_checks++; if (obs_lat !== 112) begin n_fail++; $display("FAIL basic_latency: got %0d want 112", obs_lat); end
        n_checks++; if (obs_ndone !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", obs_ndone); end
        n_checks++; if (obs_busy_at_done !== 0) begin n_fail++; $display("FAIL basic_busy_on_done: got %0d want 0", obs_busy_at_done); end
        n_checks++; if (obs_roen_last !== SETTLE + 100) begin n_fail++; $display("FAIL basic_ro_en_span: last high cycle %0d want %0d", obs_roen_last, SETTLE + 100); end
        n_checks++; if (int'(obs_count) < 19 || int'(obs_count) > 21) begin n_fail++; $display("FAIL basic_count: got %0d want 20 +/-1", obs_count); end
        n_checks++; if (obs_ovf !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b want 0", obs_ovf); end
    endtask

    task automatic test_overflow;
        int lat, nd;
        ro_half4 = 20;
        lat = -1; nd = 0;
        @(posedge clk); #1;
        gate4 = 16'd200;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int c = 1; c <= 220; c++) begin
            @(negedge clk);
            if (done4) begin
                nd++;
                if (lat < 0) lat = c;
            end
        end
        n_checks++; if (lat !== 212) begin n_fail++; $display("FAIL ovf_latency: got %0d want 212", lat); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL ovf_done_count: got %0d want 1", nd); end
        n_checks++; if (count4 !== 4'd15) begin n_fail++; $display("FAIL ovf_count: got %0d want 15", count4); end
        n_checks++; if (overflow4 !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow4); end
    endtask

    task automatic test_zero_gate;
        ro_half = 25;
        run_meas(16'd0, 0, 0, 16'd0, 20);
        n_checks++; if (obs_lat !== 12) begin n_fail++; $display("FAIL zero_latency: got %0d want 12", obs_lat); end
        n_checks++; if (obs_count !== 16'd0 || obs_ovf !== 1'b0) begin n_fail++; $display("FAIL zero_result: count %0d ovf %b want 0 0", obs_count, obs_ovf); end
        n_checks++; if (obs_roen_last !== SETTLE) begin n_fail++; $display("FAIL zero_ro_en_span: last high cycle %0d want %0d", obs_roen_last, SETTLE); end
    endtask

    task automatic test_restart_ignored;
        ro_half = 25;
        run_meas(16'd100, 1, 30, 16'd5, 118);
        n_checks++; if (obs_lat !== 112 || obs_ndone !== 1) begin n_fail++; $display("FAIL restart_done: lat %0d n %0d want 112 1", obs_lat, obs_ndone); end
        n_checks++; if (int'(obs_count) < 19 || int'(obs_count) > 21) begin n_fail++; $display("FAIL restart_count: got %0d want 20 +/-1", obs_count); end
    endtask

    task automatic test_abort_gate;
        int lo, hi;
        ro_half = 25;
        // abort driven in cycle 59 -> sampled after 50 GATE cycles
        run_meas(16'd100, 2, 59, 16'd0, 120);
        lo = exp_lo(50, 25); hi = exp_hi(50, 25);
        n_checks++; if (obs_ndone !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", obs_ndone); end
        n_checks++; if (obs_roen_last !== 59) begin n_fail++; $display("FAIL abort_ro_en: last high cycle %0d want 59", obs_roen_last); end
        n_checks++; if (obs_busy_last !== 59 + 1 + SS) begin n_fail++; $display("FAIL abort_busy: last high cycle %0d want %0d", obs_busy_last, 59 + 1 + SS); end
        n_checks++; if (int'(obs_count) < lo || int'(obs_count) > hi) begin n_fail++; $display("FAIL abort_count: got %0d want %0d..%0d", obs_count, lo, hi); end
    endtask

    task automatic test_abort_drain;
        ro_half = 25;
        // G=20: DRAIN occupies cycles 29..31; abort sampled at the edge ending cycle 29
        run_meas(16'd20, 2, 29, 16'd0, 40);
        n_checks++; if (obs_ndone !== 0) begin n_fail++; $display("FAIL drain_abort_no_done: got %0d want 0", obs_ndone); end
        n_checks++; if (obs_busy_last !== 31) begin n_fail++; $display("FAIL drain_abort_busy: last high cycle %0d want 31", obs_busy_last); end
    endtask

    task automatic test_abort_idle;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        gate_cycles = 16'd10;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || ro_en !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_start_idle: busy/ro_en high in %0d cycles want 0", bad); end
    endtask

    task automatic test_back_to_back;
        ro_half = 25;
        run_meas(16'd30, 3, 0, 16'd0, 90);
        n_checks++; if (obs_lat !== 42) begin n_fail++; $display("FAIL b2b_first: got %0d want 42", obs_lat); end
        n_checks++; if (obs_lat2 !== 42 + 42) begin n_fail++; $display("FAIL b2b_second: got %0d want %0d", obs_lat2, 84); end
    endtask

    task automatic test_reset_mid_gate;
        ro_half = 25;
        @(posedge clk); #1;
        gate_cycles = 16'd100;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(negedge clk);
        n_checks++; if (count === 16'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: count %0d busy %b want >0 1", count, busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (ro_en !== 1'b0 || busy !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: ro_en %b busy %b count %0d ovf %b want all 0", ro_en, busy, count, overflow);
        end
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        run_meas(16'd100, 0, 0, 16'd0, 118);
        n_checks++; if (obs_lat !== 112 || int'(obs_count) < 19 || int'(obs_count) > 21) begin
            n_fail++; $display("FAIL rst_rerun: lat %0d count %0d want 112 20+/-1", obs_lat, obs_count);
        end
    endtask

    task automatic test_random;
        int g, half, lo, hi;
        for (int i = 0; i < 6; i++) begin
            half = 5 * $urandom_range(3, 10);
            g = $urandom_range(1, 150);
            ro_half = half;
            lo = exp_lo(g, half);
            hi = exp_hi(g, half);
            run_meas(16'(g), 0, 0, 16'd0, g + 18);
            n_checks++; if (obs_lat !== g + 1 + SETTLE + SS + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, obs_lat, g + 12); end
            n_checks++; if (int'(obs_count) < lo || int'(obs_count) > hi || obs_ovf !== 1'b0) begin
                n_fail++; $display("FAIL rand_count[%0d]: got %0d ovf %b want %0d..%0d ovf 0 (g=%0d half=%0d)", i, obs_count, obs_ovf, lo, hi, g, half);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        start = 1'b0; abort = 1'b0; gate_cycles = 16'd0;
        start4 = 1'b0; abort4 = 1'b0; gate4 = 16'd0;
        ro_half = 25; ro_half4 = 20;
        test_reset;
        test_basic;
        test_overflow;
        test_zero_gate;
        test_restart_ignored;
        test_abort_gate;
        test_abort_drain;
        test_abort_idle;
        test_back_to_back;
        test_reset_mid_gate;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
